usb_send: RTL and testbench

- Full-speed USB packet transmitter. It is the transmit counterpart of the USB receive path in the usb-core.
- Takes a PID and a byte stream from the device/endpoint logic. Produces SYNC, the PID byte, payload bytes and an optional CRC16 on the wire, followed by EOP.
- Performs bit stuffing and NRZI encoding, and drives the pad-level J/SE0/output-enable signals at 12 Mb/s from clk_48.

---
 rtl/usb_send_pkg.sv | 43 ++++
 rtl/usb_send_if.sv | 27 ++
 rtl/usb_crc16.sv | 32 +++
 rtl/usb_tx_nrzi_stuff.sv | 46 ++++
 rtl/usb_send.sv | 178 +++++++++++++++++
 tb/tb_usb_send.sv | 280 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/usb_send_pkg.sv
// usb_send_pkg: shared constants and types for the full-speed USB transmit path.
//   - PID nibbles, SYNC byte, CRC16 polynomial/initial/residual values
//   - default clk_48 cycles per USB bit
//   - transmit FSM state encoding and PID byte helper
package usb_send_pkg;

  localparam int USB_BIT_CLKS = 4;  // 12 Mb/s from 48 MHz

  localparam logic [7:0] USB_SYNC = 8'h80;  // LSB first: 0000_0001

  // Token / data / handshake PIDs (low nibble; the byte carries ~pid above).
  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_DATA0 = 4'h3;
  localparam logic [3:0] PID_DATA1 = 4'hB;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_NAK   = 4'hA;
  localparam logic [3:0] PID_STALL = 4'hE;

  // CRC16 x^16+x^15+x^2+1. The shifter runs LSB-first, so the reflected
  // polynomial is what the hardware uses; residual is given in the same form.
  localparam logic [15:0] CRC16_POLY      = 16'h8005;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL  = 16'hB001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_CRC,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

endpackage

// File: rtl/usb_send_if.sv
// usb_send_if: endpoint-side request/data handshake plus pad drive of the
// USB transmitter.
//   master : endpoint logic (drives tx_start/tx_pid/tx_crc16/tx_data/tx_data_valid)
//   slave  : usb_send      (drives tx_data_get/tx_busy/tx_done/tx_en/tx_j/tx_se0)
interface usb_send_if;
  logic       tx_start;
  logic [3:0] tx_pid;
  logic       tx_crc16;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_get;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_en;
  logic       tx_j;
  logic       tx_se0;

  modport master (
    output tx_start, tx_pid, tx_crc16, tx_data, tx_data_valid,
    input  tx_data_get, tx_busy, tx_done, tx_en, tx_j, tx_se0
  );

  modport slave (
    input  tx_start, tx_pid, tx_crc16, tx_data, tx_data_valid,
    output tx_data_get, tx_busy, tx_done, tx_en, tx_j, tx_se0
  );
endinterface

// File: rtl/usb_crc16.sv
// usb_crc16: serial USB CRC16, LSB-first data.
//   clk, rst_n : clock / async active-low reset
//   init       : reload the initial value (packet start)
//   en, din    : shift one data bit into the remainder
//   dump       : shift the remainder out one bit (after the payload)
//   out        : complemented remainder bit currently due on the wire
module usb_crc16
  import usb_send_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic en,
  input  logic din,
  input  logic dump,
  output logic out
);

  logic [15:0] rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rem_q <= CRC16_INIT;
    else if (init)  rem_q <= CRC16_INIT;
    else if (en)    rem_q <= (rem_q >> 1) ^ ((din ^ rem_q[0]) ? CRC16_POLY_REFL : 16'h0000);
    else if (dump)  rem_q <= {1'b1, rem_q[15:1]};
  end

  // Low remainder bit leaves first, complemented, so the receiver's
  // running CRC lands on the residual.
  assign out = ~rem_q[0];

endmodule

// File: rtl/usb_tx_nrzi_stuff.sv
// usb_tx_nrzi_stuff: bit stuffer and NRZI encoder for the transmit path.
//   init   : restart from idle J with an empty ones run (packet start)
//   shift  : present the next bit this cycle (bit_in, or a stuff 0 if stalled)
//   bit_in : raw (pre-NRZI) bit
//   stall  : six 1s have gone out; the next shift carries a stuffed 0
//   line_j : NRZI line level, 1 = J
module usb_tx_nrzi_stuff (
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic shift,
  input  logic bit_in,
  output logic stall,
  output logic line_j
);

  logic       j_q;
  logic [2:0] ones_q;
  logic       base_j;
  logic [2:0] base_ones;

  // init and the first shift happen together, so start from J / zero run.
  assign base_j    = init ? 1'b1 : j_q;
  assign base_ones = init ? 3'd0 : ones_q;
  assign stall     = (ones_q == 3'd6);
  assign line_j    = j_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q    <= 1'b1;
      ones_q <= 3'd0;
    end else if (shift) begin
      if (base_ones == 3'd6) begin
        j_q    <= ~base_j;           // stuffed 0 toggles the line
        ones_q <= 3'd0;
      end else if (bit_in) begin
        j_q    <= base_j;
        ones_q <= base_ones + 3'd1;
      end else begin
        j_q    <= ~base_j;
        ones_q <= 3'd0;
      end
    end
  end

endmodule

// File: rtl/usb_send.sv
// usb_send: full-speed USB packet transmitter.
// Sends SYNC, PID byte, streamed payload, optional CRC16, then EOP, with
// bit stuffing and NRZI, one bit per BIT_CLKS cycles of clk_48.
//   clk_48, rst_n : clock / async active-low reset (aborts a packet at once)
//   bus (slave)   : tx_start/tx_pid/tx_crc16 request, tx_data/tx_data_valid/
//                   tx_data_get byte stream, tx_busy/tx_done status,
//                   tx_en/tx_j/tx_se0 pad drive
module usb_send
  import usb_send_pkg::*;
#(
  parameter int BIT_CLKS = USB_BIT_CLKS
) (
  input  logic        clk_48,
  input  logic        rst_n,
  usb_send_if.slave   bus
);

  localparam int CW = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;

  tx_state_t      state_q, nxt_state;
  logic [3:0]     idx_q, nxt_idx;       // bit within current byte / CRC
  logic [7:0]     shreg_q, nxt_shreg;   // byte on the wire, bit 0 = current
  logic [3:0]     pid_q;
  logic           crc16_q;
  logic [CW-1:0]  cnt_q;
  logic           done_q;

  logic busy, in_tx, accept, strobe, adv;
  logic nxt_has_bit, nxt_bit, src_data, src_crc, fetch;
  logic stall, line_j, crc_out;
  logic nrzi_init, nrzi_shift, nrzi_bit, crc_en, crc_dump;

  assign busy   = (state_q != ST_IDLE);
  assign in_tx  = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                  (state_q == ST_DATA) || (state_q == ST_CRC);
  // The tx_done cycle is still part of the packet from the caller's view.
  assign accept = bus.tx_start && (state_q == ST_IDLE) && !done_q;
  assign strobe = busy && (cnt_q == CW'(BIT_CLKS - 1));
  // A stuffed bit holds the sequencer, the byte fetch and the CRC.
  assign adv    = strobe && !(stall && in_tx);

  // State register
  always_ff @(posedge clk_48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      shreg_q <= 8'h00;
      pid_q   <= 4'h0;
      crc16_q <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        state_q <= ST_SYNC;
        idx_q   <= 4'd0;
        shreg_q <= USB_SYNC;
        pid_q   <= bus.tx_pid;
        crc16_q <= bus.tx_crc16;
        cnt_q   <= '0;
      end else if (busy) begin
        cnt_q <= strobe ? '0 : cnt_q + CW'(1);
        if (adv) begin
          state_q <= nxt_state;
          idx_q   <= nxt_idx;
          shreg_q <= nxt_shreg;
          if (state_q == ST_EOP_J) done_q <= 1'b1;
        end
      end
    end
  end

  // Next state: where the sequencer goes and which raw bit it presents
  // when the current bit time ends without a stuff.
  always_comb begin
    nxt_state   = state_q;
    nxt_idx     = idx_q;
    nxt_shreg   = shreg_q;
    nxt_has_bit = 1'b0;
    nxt_bit     = 1'b0;
    src_data    = 1'b0;
    src_crc     = 1'b0;
    fetch       = 1'b0;
    case (state_q)
      ST_SYNC, ST_PID, ST_DATA: begin
        if (idx_q != 4'd7) begin
          nxt_idx     = idx_q + 4'd1;
          nxt_shreg   = {1'b0, shreg_q[7:1]};
          nxt_has_bit = 1'b1;
          nxt_bit     = shreg_q[1];
          src_data    = (state_q == ST_DATA);
        end else if (state_q == ST_SYNC) begin
          nxt_state   = ST_PID;
          nxt_idx     = 4'd0;
          nxt_shreg   = pid_byte(pid_q);
          nxt_has_bit = 1'b1;
          nxt_bit     = nxt_shreg[0];
        end else begin
          // Last bit of PID or payload byte: pull the next byte or finish.
          fetch   = 1'b1;
          nxt_idx = 4'd0;
          if (bus.tx_data_valid) begin
            nxt_state   = ST_DATA;
            nxt_shreg   = bus.tx_data;
            nxt_has_bit = 1'b1;
            nxt_bit     = bus.tx_data[0];
            src_data    = 1'b1;
          end else if (crc16_q) begin
            nxt_state   = ST_CRC;
            nxt_has_bit = 1'b1;
            nxt_bit     = crc_out;
            src_crc     = 1'b1;
          end else begin
            nxt_state = ST_EOP_SE0;
          end
        end
      end
      ST_CRC: begin
        if (idx_q != 4'd15) begin
          nxt_idx     = idx_q + 4'd1;
          nxt_has_bit = 1'b1;
          nxt_bit     = crc_out;
          src_crc     = 1'b1;
        end else begin
          nxt_state = ST_EOP_SE0;
          nxt_idx   = 4'd0;
        end
      end
      ST_EOP_SE0: begin
        if (idx_q == 4'd0) nxt_idx = 4'd1;
        else begin
          nxt_state = ST_EOP_J;
          nxt_idx   = 4'd0;
        end
      end
      ST_EOP_J: nxt_state = ST_IDLE;
      default: ;
    endcase
  end

  // Outputs and datapath strobes
  always_comb begin
    nrzi_init = accept;
    // Stuff bits and data bits both shift the encoder; entering EOP does not.
    nrzi_shift = accept || (strobe && in_tx && (stall || nxt_has_bit));
    nrzi_bit   = accept ? USB_SYNC[0] : nxt_bit;
    crc_en     = adv && src_data;
    crc_dump   = adv && src_crc;

    bus.tx_data_get = adv && fetch && bus.tx_data_valid;
    bus.tx_busy     = busy;
    bus.tx_done     = done_q;
    bus.tx_en       = busy;
    bus.tx_se0      = (state_q == ST_EOP_SE0);
    bus.tx_j        = in_tx ? line_j : 1'b1;
  end

  usb_tx_nrzi_stuff u_nrzi (
    .clk    (clk_48),
    .rst_n  (rst_n),
    .init   (nrzi_init),
    .shift  (nrzi_shift),
    .bit_in (nrzi_bit),
    .stall  (stall),
    .line_j (line_j)
  );

  usb_crc16 u_crc (
    .clk   (clk_48),
    .rst_n (rst_n),
    .init  (accept),
    .en    (crc_en),
    .din   (nxt_bit),
    .dump  (crc_dump),
    .out   (crc_out)
  );

endmodule

// File: tb/tb_usb_send.sv
module tb_usb_send;

  logic clk_48;
  logic rst_n;
  usb_send_if u();

  usb_send #(.BIT_CLKS(4)) dut (
    .clk_48 (clk_48),
    .rst_n  (rst_n),
    .bus    (u)
  );

  initial begin
    clk_48 = 1'b0;
    forever #5 clk_48 = ~clk_48;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard of expected wire bytes and the payload source queue.
  logic [7:0] sb[$];
  logic [7:0] src_q[$];

  // ---------------- payload source ----------------
  initial begin
    u.tx_data_valid = 1'b0;
    u.tx_data = 8'h00;
    forever begin
      @(negedge clk_48);
      if (u.tx_data_get && src_q.size() > 0) begin
        @(posedge clk_48);
        #1;
        void'(src_q.pop_front());
      end
      u.tx_data_valid = (src_q.size() > 0);
      u.tx_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end

  // ---------------- line decoder ----------------
  int ph, ones, nb, nbytes, se0_bits, j_bits, en_cyc, stuff_cnt;
  int get_cnt, done_cnt;
  bit prev_en, prev_j, in_eop;
  logic [7:0] acc;
  logic [15:0] resid;

  task automatic sample_bit();
    bit raw;
    logic [7:0] e;
    if (u.tx_se0) begin
      in_eop = 1'b1;
      se0_bits++;
    end else if (in_eop) begin
      j_bits++;
      chk("eop_j_level", u.tx_j, 1);
    end else begin
      raw = (u.tx_j == prev_j);
      prev_j = u.tx_j;
      if (ones == 6) begin
        stuff_cnt++;
        chk("stuff_bit", raw, 0);
        ones = 0;
      end else begin
        ones = raw ? ones + 1 : 0;
        acc = {raw, acc[7:1]};
        if (nbytes >= 2)
          resid = ((resid[0] ^ raw) != 1'b0) ? ((resid >> 1) ^ 16'hA001) : (resid >> 1);
        nb++;
        if (nb == 8) begin
          nb = 0;
          if (sb.size() == 0) chk($sformatf("extra_byte%0d", nbytes), 1, 0);
          else begin
            e = sb.pop_front();
            chk($sformatf("byte%0d", nbytes), acc, e);
          end
          nbytes++;
        end
      end
    end
  endtask

  initial begin
    prev_en = 1'b0;
    forever begin
      @(negedge clk_48);
      if (u.tx_done) done_cnt++;
      if (u.tx_en) begin
        if (!prev_en) begin
          ph = 0; prev_j = 1'b1; ones = 0; nb = 0; nbytes = 0; se0_bits = 0;
          j_bits = 0; en_cyc = 0; in_eop = 1'b0; stuff_cnt = 0; resid = 16'hFFFF;
        end else ph++;
        en_cyc++;
        if (u.tx_data_get) begin
          get_cnt++;
          chk("get_in_last_clk_of_bit", ph % 4, 3);
        end
        if (ph % 4 == 2) sample_bit();
      end
      prev_en = u.tx_en;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [15:0] crc_byte(input logic [15:0] r, input logic [7:0] b);
    for (int i = 0; i < 8; i++)
      r = ((r[0] ^ b[i]) != 1'b0) ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    return r;
  endfunction

  int exp_stuffs, exp_en_cur;

  task automatic start_pkt(input logic [3:0] pid, input bit crc, input int n,
                           input logic [3:0][7:0] d, input int exp_en);
    logic [7:0] bytes[$];
    logic [15:0] r;
    int o;
    bytes = {};
    bytes.push_back(8'h80);
    bytes.push_back({~pid, pid});
    r = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      bytes.push_back(d[i]);
      src_q.push_back(d[i]);
      r = crc_byte(r, d[i]);
    end
    if (crc) begin
      bytes.push_back(~r[7:0]);
      bytes.push_back(~r[15:8]);
    end
    exp_stuffs = 0;
    o = 0;
    foreach (bytes[k]) begin
      sb.push_back(bytes[k]);
      for (int b = 0; b < 8; b++) begin
        o = bytes[k][b] ? o + 1 : 0;
        if (o == 6) begin exp_stuffs++; o = 0; end
      end
    end
    exp_en_cur = (exp_en != 0) ? exp_en : (bytes.size() * 8 + exp_stuffs + 3) * 4;
    get_cnt = 0;
    done_cnt = 0;
    @(negedge clk_48);
    u.tx_pid = pid;
    u.tx_crc16 = crc;
    u.tx_start = 1'b1;
    @(posedge clk_48);
    #1;
    u.tx_start = 1'b0;
    u.tx_pid = ~pid;       // must have been latched
    u.tx_crc16 = ~crc;
    chk("busy_after_start", u.tx_busy, 1);
    chk("en_after_start", u.tx_en, 1);
    chk("first_sync_bit_K", u.tx_j, 0);
  endtask

  task automatic run_pkt(input logic [3:0] pid, input bit crc, input int n,
                         input logic [3:0][7:0] d, input int exp_en,
                         input int mid_start, input bit start_on_done);
    int cyc;
    bit seen;
    start_pkt(pid, crc, n, d, exp_en);
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk_48);
      cyc++;
      if (u.tx_done) seen = 1'b1;
      else if (cyc == mid_start) begin
        u.tx_start = 1'b1;
        u.tx_pid = 4'h5;
        u.tx_crc16 = 1'b0;
        @(posedge clk_48);
        #1;
        u.tx_start = 1'b0;
      end
    end
    chk("done_seen_in_time", seen, 1);
    if (start_on_done) begin
      u.tx_start = 1'b1;
      @(posedge clk_48);
      #1;
      u.tx_start = 1'b0;
      chk("start_on_done_ignored", u.tx_busy, 0);
    end
    repeat (8) @(negedge clk_48);
    chk("done_pulses", done_cnt, 1);
    chk("get_pulses", get_cnt, n);
    chk("en_cycles", en_cyc, exp_en_cur);
    chk("stuff_count", stuff_cnt, exp_stuffs);
    chk("se0_bits", se0_bits, 2);
    chk("eop_j_bits", j_bits, 1);
    chk("partial_bits", nb, 0);
    chk("bytes_missing", sb.size(), 0);
    if (crc) chk("crc_residual", resid, 16'hB001);
    sb.delete();
    src_q.delete();
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    logic [3:0]       pid;
    bit               crc;
    int               n;
    logic [3:0][7:0]  d;
    int               exp_en;   // 0: derive from model
  } vec_t;

  vec_t vecs[7];

  initial begin
    int cyc;
    logic [3:0][7:0] dz;
    vecs[0] = '{pid: 4'h2, crc: 1'b0, n: 0, d: 32'h0,         exp_en: 76};   // ACK
    vecs[1] = '{pid: 4'h3, crc: 1'b1, n: 0, d: 32'h0,         exp_en: 140};  // zero-length DATA0
    vecs[2] = '{pid: 4'hB, crc: 1'b1, n: 2, d: 32'h0000FFFF,  exp_en: 0};    // stuffing
    vecs[3] = '{pid: 4'h3, crc: 1'b1, n: 3, d: 32'h00030201,  exp_en: 0};    // streaming
    vecs[4] = '{pid: 4'hA, crc: 1'b0, n: 0, d: 32'h0,         exp_en: 76};   // NAK
    vecs[5] = '{pid: 4'hB, crc: 1'b1, n: 4, d: 32'h80FF7E00,  exp_en: 0};
    vecs[6] = '{pid: 4'h3, crc: 1'b0, n: 1, d: 32'h000000FC,  exp_en: 0};
    dz = 32'h0;

    u.tx_start = 1'b0;
    u.tx_pid = 4'h0;
    u.tx_crc16 = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_48);
    chk("rst_en", u.tx_en, 0);
    chk("rst_j", u.tx_j, 1);
    chk("rst_se0", u.tx_se0, 0);
    chk("rst_busy", u.tx_busy, 0);
    chk("rst_done", u.tx_done, 0);
    chk("rst_get", u.tx_data_get, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_48);

    for (int i = 0; i < 7; i++)
      run_pkt(vecs[i].pid, vecs[i].crc, vecs[i].n, vecs[i].d, vecs[i].exp_en, 0, 1'b0);

    // tx_start mid-packet and on the tx_done cycle are both ignored.
    run_pkt(4'h3, 1'b1, 2, 32'h0000A55A, 0, 90, 1'b1);

    // Reset mid-DATA aborts at once with no EOP and no tx_done.
    start_pkt(4'hB, 1'b1, 4, 32'h44332211, 0);
    cyc = 0;
    while (get_cnt < 2 && cyc < 2000) begin
      @(negedge clk_48);
      cyc++;
    end
    chk("reached_data_before_abort", (get_cnt >= 2) ? 1 : 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_en", u.tx_en, 0);
    chk("abort_j", u.tx_j, 1);
    chk("abort_se0", u.tx_se0, 0);
    chk("abort_busy", u.tx_busy, 0);
    repeat (10) @(negedge clk_48);
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_se0", se0_bits, 0);
    sb.delete();
    src_q.delete();
    rst_n = 1'b1;
    repeat (2) @(negedge clk_48);
    run_pkt(4'h3, 1'b1, 3, 32'h00030201, 0, 0, 1'b0);
    run_pkt(4'h2, 1'b0, 0, dz, 76, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
